// File: rtl/msg_pkg.sv
// Shared types and helpers for the message output buffer.
package msg_pkg;

    localparam int MSG_DATA_W    = 256;
    localparam int MSG_SIZE_W    = 6;
    localparam int MSG_MAX_BYTES = 32;

    // Largest size an entry may carry; larger requests are truncated to this.
    localparam logic [MSG_SIZE_W-1:0] MSG_MAX_SIZE = 6'd32;

    // One buffered message: truncation flag, clamped byte count, payload.
    typedef struct packed {
        logic                  err;
        logic [MSG_SIZE_W-1:0] size;
        logic [MSG_DATA_W-1:0] data;
    } msg_entry_t;

    // Byte-valid mask: bit i set iff byte i lies below size.
    function automatic logic [MSG_MAX_BYTES-1:0] size_to_mask(input logic [MSG_SIZE_W-1:0] size);
        logic [MSG_MAX_BYTES-1:0] m;
        for (int i = 0; i < MSG_MAX_BYTES; i++) begin
            m[i] = (i < int'(size));
        end
        return m;
    endfunction

endpackage

// File: rtl/msg_sync_fifo.sv
// Generic show-ahead synchronous FIFO. rd_data always presents the head entry;
// storage is reset so that rd_data reads as zero straight out of reset.
module msg_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    output logic          full,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    // A write into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage write; when full with a simultaneous pop the slot being vacated is reused.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/msg_output_buffer.sv
// Buffers extractor messages (no backpressure upstream) and re-issues them on a
// valid/ready stream with a byte mask, counting drops and truncations.
//
// Output handshake: an entry transfers on a rising clk edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 all out_* hold steady;
// out_valid never depends combinationally on out_ready or on any in_* input.
module msg_output_buffer
    import msg_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int DATA_W = 256,
    parameter int SIZE_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SIZE_W-1:0] in_size,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SIZE_W-1:0] out_size,
    output logic [31:0]       out_bytemask,
    output logic              out_error,
    output logic [AW:0]       fill_level,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_count,
    output logic [CNT_W-1:0]  err_count,
    input  logic              clear
);

    logic              push_req;
    logic              trunc;
    logic [SIZE_W-1:0] size_c;
    logic [31:0]       in_mask;
    logic [DATA_W-1:0] data_c;
    msg_entry_t        wr_entry;
    msg_entry_t        head;
    logic              full;
    logic              empty;
    logic              pop;
    logic              wr_en;
    logic              drop_evt;
    logic              err_evt;

    // Zero-size strobes carry nothing and are ignored outright.
    assign push_req = in_valid && (in_size != '0);
    assign trunc    = (in_size > MSG_MAX_SIZE);
    assign size_c   = trunc ? MSG_MAX_SIZE : in_size;
    assign in_mask  = size_to_mask(size_c);

    // Force bytes above the stored size to zero before they enter the FIFO.
    always_comb begin
        data_c = '0;
        for (int i = 0; i < MSG_MAX_BYTES; i++) begin
            data_c[8*i +: 8] = in_data[8*i +: 8] & {8{in_mask[i]}};
        end
    end

    assign wr_entry = '{err: trunc, size: size_c, data: data_c};

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign wr_en     = push_req && (!full || pop);
    assign drop_evt  = push_req && full && !pop;
    assign err_evt   = wr_en && trunc;

    msg_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     ($bits(msg_entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .full    (full),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (empty),
        .count   (fill_level)
    );

    assign out_data     = head.data;
    assign out_size     = head.size;
    assign out_error    = head.err;
    assign out_bytemask = size_to_mask(head.size);

    // CSR flags: clear dominates; counters saturate at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
            err_count  <= '0;
        end else if (clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
            err_count  <= '0;
        end else begin
            if (drop_evt) overflow <= 1'b1;
            if (drop_evt && (drop_count != '1)) drop_count <= drop_count + 1'b1;
            if (err_evt && (err_count != '1)) err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_msg_output_buffer.sv
// Directed bench for msg_output_buffer.
module tb_msg_output_buffer;

    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int DATA_W = 256;
    localparam int SIZE_W = 6;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [SIZE_W-1:0] in_size;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [SIZE_W-1:0] out_size;
    logic [31:0]       out_bytemask;
    logic              out_error;
    logic [AW:0]       fill_level;
    logic              overflow;
    logic [CNT_W-1:0]  drop_count;
    logic [CNT_W-1:0]  err_count;
    logic              clear;

    int total = 0;
    int bad   = 0;
    logic [SIZE_W-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    msg_output_buffer #(
        .DEPTH (DEPTH), .AW (AW), .DATA_W (DATA_W), .SIZE_W (SIZE_W), .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_size      (in_size),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_size     (out_size),
        .out_bytemask (out_bytemask),
        .out_error    (out_error),
        .fill_level   (fill_level),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .err_count    (err_count),
        .clear        (clear)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] exp_data(input int sz);
        logic [DATA_W-1:0] one;
        one = 1;
        return (one << (8 * sz)) - 1;
    endfunction

    function automatic logic [31:0] exp_mask(input int sz);
        logic [63:0] one;
        one = 1;
        return 32'((one << sz) - 1);
    endfunction

    // driver: single-cycle message strobe
    task automatic push(input int sz, input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_size  = SIZE_W'(sz);
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_size   = '0;
        out_ready = 1'b0;
        clear     = 1'b0;
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_size", out_size, 0);
        check("rst_mask", out_bytemask, 0);
        check("rst_fill", fill_level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_count, 0);
        check("rst_err", err_count, 0);
        reset_n = 1'b1;
        tick();

        // 1: single message, junk above byte 4 must be zeroed
        push(5, {216'hDEAD_BEEF_1234, 40'hAABBCCDDEE});
        check("t1_valid", out_valid, 1);
        check("t1_size", out_size, 5);
        check("t1_mask", out_bytemask, 32'h1F);
        check("t1_data", out_data, 256'hAABBCCDDEE);
        check("t1_error", out_error, 0);
        check("t1_fill", fill_level, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_empty", out_valid, 0);

        // 2: nine pushes into eight entries with no consumer
        for (int s = 1; s <= 9; s++) begin
            push(s, '1);
            if (s <= 8) exp_q.push_back(SIZE_W'(s));
        end
        check("t2_fill", fill_level, 8);
        check("t2_ovf", overflow, 1);
        check("t2_drop", drop_count, 1);
        tick();
        tick();
        check("t2_hold_size", out_size, 1);
        check("t2_hold_data", out_data, exp_data(1));

        // 3: full, pop and push in the same cycle
        out_ready = 1'b1;
        check("t3_head", out_size, exp_q.pop_front());
        push(12, '1);
        exp_q.push_back(6'd12);
        check("t3_fill", fill_level, 8);
        check("t3_drop", drop_count, 1);
        for (int n = 0; n < 8; n++) begin
            logic [SIZE_W-1:0] e;
            e = exp_q.pop_front();
            check("drain_valid", out_valid, 1);
            check("drain_size", out_size, e);
            check("drain_mask", out_bytemask, exp_mask(int'(e)));
            check("drain_data", out_data, exp_data(int'(e)));
            tick();
        end
        out_ready = 1'b0;
        check("t3_empty", out_valid, 0);
        check("t3_q", exp_q.size(), 0);

        // 4: truncation, then a zero-size strobe
        push(40, '1);
        check("t4_size", out_size, 32);
        check("t4_error", out_error, 1);
        check("t4_mask", out_bytemask, 32'hFFFF_FFFF);
        check("t4_data", out_data, {DATA_W{1'b1}});
        check("t4_errcnt", err_count, 1);
        push(0, '1);
        check("t4_zero_fill", fill_level, 1);
        check("t4_zero_drop", drop_count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 5: saturation and clear
        for (int n = 0; n < 8; n++) push(1, '1);
        in_valid = 1'b1;
        in_size  = 6'd1;
        for (int n = 0; n < 65540; n++) tick();
        in_valid = 1'b0;
        tick();
        check("t5_sat", drop_count, 16'hFFFF);
        check("t5_ovf", overflow, 1);
        clear    = 1'b1;
        in_valid = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("t5_clr_drop", drop_count, 0);
        check("t5_clr_ovf", overflow, 0);
        check("t5_clr_err", err_count, 0);
        check("t5_fill", fill_level, 8);

        // 6: asynchronous flush with three entries queued
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        out_ready = 1'b0;
        check("t6_fill3", fill_level, 3);
        reset_n = 1'b0;
        #2;
        check("t6_valid", out_valid, 0);
        check("t6_fill", fill_level, 0);
        check("t6_data", out_data, 0);
        check("t6_size", out_size, 0);
        check("t6_mask", out_bytemask, 0);
        reset_n = 1'b1;
        tick();
        push(5, {216'h55, 40'hAABBCCDDEE});
        check("t6_re_valid", out_valid, 1);
        check("t6_re_size", out_size, 5);
        check("t6_re_data", out_data, 256'hAABBCCDDEE);
        check("t6_re_fill", fill_level, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
